// File: rtl/reg_slice_bwd_if.sv
// Valid/ready stream bundle around the backward register slice.
// It carries the upstream (s_*) and downstream (m_*) channel signals.
interface reg_slice_bwd_if #(
    parameter int PLD_WIDTH = 32
);
    logic                 s_vld;
    logic                 s_rdy;
    logic [PLD_WIDTH-1:0] s_pld;
    logic                 m_vld;
    logic                 m_rdy;
    logic [PLD_WIDTH-1:0] m_pld;

    // Slice-side view: consumes the upstream channel and produces the downstream channel.
    modport slave (
        input  s_vld,
        input  s_pld,
        input  m_rdy,
        output s_rdy,
        output m_vld,
        output m_pld
    );

    // Environment-side view: drives the stream into the slice and the ready back.
    modport master (
        output s_vld,
        output s_pld,
        output m_rdy,
        input  s_rdy,
        input  m_vld,
        input  m_pld
    );
endinterface

// File: rtl/reg_slice_bwd.sv
// Backward-path register slice: cuts m_rdy -> s_rdy with a single skid entry.
// Valid and payload pass straight through while the skid is empty.
module reg_slice_bwd #(
    parameter int PLD_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    reg_slice_bwd_if.slave    bus,
    output logic              skid_vld
);
    logic                 skid_vld_q, skid_vld_d;
    logic [PLD_WIDTH-1:0] skid_pld_q, skid_pld_d;
    logic                 rdy_q, rdy_d;
    logic                 up_xfer;

    assign up_xfer = bus.s_vld & rdy_q;

    // Load and drain never coincide: rdy_q is low whenever the skid is full.
    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_pld_d = skid_pld_q;
        rdy_d      = rdy_q;
        if (up_xfer && !bus.m_rdy) begin
            skid_vld_d = 1'b1;
            skid_pld_d = bus.s_pld;
            rdy_d      = 1'b0;
        end else if (skid_vld_q && bus.m_rdy) begin
            skid_vld_d = 1'b0;
            rdy_d      = 1'b1;
        end
    end

    // rdy_q mirrors ~skid_vld_q but is a separate flop so s_rdy leaves a register directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld_q <= 1'b0;
            skid_pld_q <= '0;
            rdy_q      <= 1'b1;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_pld_q <= skid_pld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign bus.s_rdy = rdy_q;
    assign bus.m_vld = skid_vld_q | bus.s_vld;
    assign bus.m_pld = skid_vld_q ? skid_pld_q : bus.s_pld;
    assign skid_vld  = skid_vld_q;
endmodule

// File: tb/tb_reg_slice_bwd.sv
// Self-checking bench for reg_slice_bwd: directed scenarios plus a random scoreboard run.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_reg_slice_bwd;
    localparam int W = 32;

    logic clk;
    logic rst;
    logic skid_vld;

    int checkCount = 0;
    int passCount  = 0;
    logic [W-1:0] expQ[$];

    reg_slice_bwd_if #(.PLD_WIDTH(W)) bus ();

    reg_slice_bwd #(.PLD_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .skid_vld (skid_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The ready flop must always be the complement of the skid flag.
    always @(negedge clk) begin
        checkCount++;
        if (bus.s_rdy !== ~skid_vld)
            $display("[TB] FAIL rdy_inv: s_rdy=%b skid_vld=%b required s_rdy=%b", bus.s_rdy, skid_vld, ~skid_vld);
        else
            passCount++;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_vld = 1'b1;
        bus.s_pld = 32'h1234;
        bus.m_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if ({bus.s_rdy, bus.m_vld, bus.m_pld, skid_vld} !== {1'b1, 1'b1, 32'h1234, 1'b0})
            $display("[TB] FAIL reset_hold: s_rdy=%b m_vld=%b m_pld=%h skid=%b required 1 1 00001234 0",
                     bus.s_rdy, bus.m_vld, bus.m_pld, skid_vld);
        else passCount++;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({bus.s_rdy, bus.m_vld, bus.m_pld, skid_vld} !== {1'b1, 1'b1, 32'h1234, 1'b0})
            $display("[TB] FAIL reset_release: s_rdy=%b m_vld=%b m_pld=%h skid=%b required 1 1 00001234 0",
                     bus.s_rdy, bus.m_vld, bus.m_pld, skid_vld);
        else passCount++;
        bus.s_vld = 1'b0;
        nextCycle();
    endtask

    task automatic test_bypass();
        int xfers = 0;
        bus.m_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.s_vld = 1'b1;
            bus.s_pld = W'(i);
            expQ.push_back(W'(i));
            @(negedge clk);
            checkCount++;
            if (bus.s_rdy !== 1'b1 || skid_vld !== 1'b0)
                $display("[TB] FAIL bypass_rdy: s_rdy=%b skid=%b required 1 0", bus.s_rdy, skid_vld);
            else passCount++;
            if (bus.m_vld && bus.m_rdy) begin
                logic [W-1:0] e;
                e = expQ.pop_front();
                xfers++;
                checkCount++;
                if (bus.m_pld !== e)
                    $display("[TB] FAIL bypass_pld: m_pld=%h required %h", bus.m_pld, e);
                else passCount++;
            end
            nextCycle();
        end
        bus.s_vld = 1'b0;
        checkCount++;
        if (xfers != 8)
            $display("[TB] FAIL bypass_count: transfers=%0d required 8", xfers);
        else passCount++;
        expQ.delete();
    endtask

    task automatic test_backpressure();
        bus.m_rdy = 1'b0;
        bus.s_vld = 1'b1;
        bus.s_pld = 32'hA5;
        @(negedge clk);
        checkCount++;
        if (bus.s_rdy !== 1'b1)
            $display("[TB] FAIL bp_accept: s_rdy=%b required 1", bus.s_rdy);
        else passCount++;
        nextCycle();
        bus.s_pld = 32'hB6;
        @(negedge clk);
        checkCount++;
        if ({skid_vld, bus.s_rdy, bus.m_vld, bus.m_pld} !== {1'b1, 1'b0, 1'b1, 32'hA5})
            $display("[TB] FAIL bp_capture: skid=%b s_rdy=%b m_vld=%b m_pld=%h required 1 0 1 000000a5",
                     skid_vld, bus.s_rdy, bus.m_vld, bus.m_pld);
        else passCount++;
        nextCycle();
        bus.m_rdy = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({bus.m_vld, bus.m_pld, bus.s_rdy} !== {1'b1, 32'hA5, 1'b0})
            $display("[TB] FAIL bp_drain: m_vld=%b m_pld=%h s_rdy=%b required 1 000000a5 0",
                     bus.m_vld, bus.m_pld, bus.s_rdy);
        else passCount++;
        nextCycle();
        @(negedge clk);
        checkCount++;
        if ({bus.s_rdy, skid_vld, bus.m_vld, bus.m_pld} !== {1'b1, 1'b0, 1'b1, 32'hB6})
            $display("[TB] FAIL bp_next: s_rdy=%b skid=%b m_vld=%b m_pld=%h required 1 0 1 000000b6",
                     bus.s_rdy, skid_vld, bus.m_vld, bus.m_pld);
        else passCount++;
        nextCycle();
        bus.s_vld = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({skid_vld, bus.m_vld} !== 2'b00)
            $display("[TB] FAIL bp_idle: skid=%b m_vld=%b required 0 0", skid_vld, bus.m_vld);
        else passCount++;
        nextCycle();
    endtask

    task automatic test_long_stall();
        bus.m_rdy = 1'b0;
        bus.s_vld = 1'b1;
        bus.s_pld = 32'h77;
        nextCycle();
        bus.s_pld = 32'h88;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkCount++;
            if ({bus.m_vld, bus.m_pld, bus.s_rdy} !== {1'b1, 32'h77, 1'b0})
                $display("[TB] FAIL stall_hold%0d: m_vld=%b m_pld=%h s_rdy=%b required 1 00000077 0",
                         i, bus.m_vld, bus.m_pld, bus.s_rdy);
            else passCount++;
            nextCycle();
        end
        bus.s_vld = 1'b0;
        bus.m_rdy = 1'b1;
        @(negedge clk);
        checkCount++;
        if (bus.m_pld !== 32'h77)
            $display("[TB] FAIL stall_release: m_pld=%h required 00000077", bus.m_pld);
        else passCount++;
        nextCycle();
        @(negedge clk);
        checkCount++;
        if ({skid_vld, bus.m_vld} !== 2'b00)
            $display("[TB] FAIL stall_empty: skid=%b m_vld=%b required 0 0", skid_vld, bus.m_vld);
        else passCount++;
        nextCycle();
    endtask

    task automatic test_reset_mid();
        bus.m_rdy = 1'b0;
        bus.s_vld = 1'b1;
        bus.s_pld = 32'h55;
        nextCycle();
        bus.s_vld = 1'b0;
        #1;
        checkCount++;
        if (skid_vld !== 1'b1)
            $display("[TB] FAIL rstmid_loaded: skid=%b required 1", skid_vld);
        else passCount++;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({skid_vld, bus.s_rdy} !== 2'b01)
            $display("[TB] FAIL rstmid_async: skid=%b s_rdy=%b required 0 1", skid_vld, bus.s_rdy);
        else passCount++;
        nextCycle();
        rst = 1'b0;
        bus.m_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++;
            if (bus.m_vld !== 1'b0)
                $display("[TB] FAIL rstmid_nodeliver%0d: m_vld=%b m_pld=%h required m_vld 0", i, bus.m_vld, bus.m_pld);
            else passCount++;
            nextCycle();
        end
    endtask

    task automatic test_random();
        int beats = 0;
        int cycles = 0;
        int vldPct = 50;
        int rdyPct = 50;
        logic pending = 1'b0;
        expQ.delete();
        while (beats < 10000 && cycles < 90000) begin
            if (cycles % 100 == 0) begin
                vldPct = $urandom_range(0, 100);
                rdyPct = $urandom_range(0, 100);
                if (vldPct < 5) vldPct = 5;
                if (rdyPct < 5) rdyPct = 5;
                if (cycles % 1000 == 0) begin
                    vldPct = (cycles % 2000 == 0) ? 100 : 0;
                    rdyPct = 100;
                    if (vldPct == 0) vldPct = 1;
                end
            end
            if (!pending) begin
                bus.s_vld = ($urandom_range(0, 99) < vldPct);
                bus.s_pld = $urandom;
            end
            bus.m_rdy = ($urandom_range(0, 99) < rdyPct);
            @(negedge clk);
            if (bus.s_vld && bus.s_rdy)
                expQ.push_back(bus.s_pld);
            if (bus.m_vld && bus.m_rdy) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL rand_extra: m_pld=%h delivered with nothing outstanding", bus.m_pld);
                end else begin
                    logic [W-1:0] e;
                    e = expQ.pop_front();
                    if (bus.m_pld !== e)
                        $display("[TB] FAIL rand_order beat %0d: m_pld=%h required %h", beats, bus.m_pld, e);
                    else passCount++;
                end
                beats++;
            end
            pending = bus.s_vld && !bus.s_rdy;
            nextCycle();
            cycles++;
        end
        checkCount++;
        if (beats < 10000)
            $display("[TB] FAIL rand_budget: beats=%0d required 10000 within 90000 cycles", beats);
        else passCount++;
        bus.s_vld = pending;
        bus.m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.s_vld && bus.s_rdy)
                expQ.push_back(bus.s_pld);
            if (bus.m_vld && bus.m_rdy) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL rand_drain_extra: m_pld=%h delivered with nothing outstanding", bus.m_pld);
                end else begin
                    logic [W-1:0] e;
                    e = expQ.pop_front();
                    if (bus.m_pld !== e)
                        $display("[TB] FAIL rand_drain_order: m_pld=%h required %h", bus.m_pld, e);
                    else passCount++;
                end
            end
            nextCycle();
            bus.s_vld = 1'b0;
        end
        checkCount++;
        if (expQ.size() != 0)
            $display("[TB] FAIL rand_lost: outstanding=%0d required 0", expQ.size());
        else passCount++;
    endtask

    initial begin
        rst = 1'b1;
        bus.s_vld = 1'b0;
        bus.s_pld = '0;
        bus.m_rdy = 1'b0;
        test_reset();
        test_bypass();
        test_backpressure();
        test_long_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
